// File: rtl/m1_sequencer.sv
// 8085 opcode-fetch / register MOV sequencer: steps T1..T5 with wait states and HALT, decoding strobes from state and opcode.
// Fetch takes 4 cycles, MOV 5, and each wait state adds 1; ready stalls in TW and there is no other backpressure.
module m1_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic [7:0] data_in,
  output logic [2:0] t_state,
  output logic       ale,
  output logic       rd_n,
  output logic       halt_ack,
  output logic       pc_rw,
  output logic       bc_rw,
  output logic       de_rw,
  output logic       hl_rw,
  output logic       dreg_rd,
  output logic       dreg_wr,
  output logic       dreg_inc,
  output logic       dreg_cnt,
  output logic       rreg_rd,
  output logic       lreg_rd,
  output logic       rreg_wr,
  output logic       lreg_wr,
  output logic       dbus_to_instr_reg,
  output logic       write_dbus_to_alu_tmp,
  output logic       alu_a_to_dbus,
  output logic       sel_alu_a
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_TW   = 3'd6,
    S_HALT = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] op_q, op_d;

  logic [2:0] ddd;
  logic [2:0] sss;
  logic       is_mov;

  // Register codes B/C, D/E, H/L share a pair; bit 0 picks the byte.
  function automatic logic [2:0] pair_sel(input logic [2:0] code);
    case (code[2:1])
      2'b00:   pair_sel = 3'b100;
      2'b01:   pair_sel = 3'b010;
      2'b10:   pair_sel = 3'b001;
      default: pair_sel = 3'b000;
    endcase
  endfunction

  assign ddd     = op_q[5:3];
  assign sss     = op_q[2:0];
  assign is_mov  = (op_q[7:6] == 2'b01) && (ddd <= 3'd5) && (sss <= 3'd5);
  assign t_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    op_d                  = op_q;
    ale                   = 1'b0;
    rd_n                  = 1'b1;
    halt_ack              = 1'b0;
    pc_rw                 = 1'b0;
    bc_rw                 = 1'b0;
    de_rw                 = 1'b0;
    hl_rw                 = 1'b0;
    dreg_rd               = 1'b0;
    dreg_wr               = 1'b0;
    dreg_inc              = 1'b0;
    dreg_cnt              = 1'b0;
    rreg_rd               = 1'b0;
    lreg_rd               = 1'b0;
    rreg_wr               = 1'b0;
    lreg_wr               = 1'b0;
    dbus_to_instr_reg     = 1'b0;
    write_dbus_to_alu_tmp = 1'b0;
    alu_a_to_dbus         = 1'b0;
    sel_alu_a             = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_T1;
      S_T1: begin
        ale     = 1'b1;
        pc_rw   = 1'b1;
        dreg_rd = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        pc_rw    = 1'b1;
        dreg_inc = 1'b1;
        dreg_cnt = 1'b1;
        rd_n     = 1'b0;
        state_d  = ready ? S_T3 : S_TW;
      end
      S_TW: begin
        rd_n    = 1'b0;
        state_d = ready ? S_T3 : S_TW;
      end
      S_T3: begin
        rd_n              = 1'b0;
        dbus_to_instr_reg = 1'b1;
        op_d              = data_in;
        state_d           = S_T4;
      end
      S_T4: begin
        if (is_mov) begin
          {bc_rw, de_rw, hl_rw} = pair_sel(sss);
          rreg_rd               = sss[0];
          lreg_rd               = ~sss[0];
          write_dbus_to_alu_tmp = 1'b1;
          state_d               = S_T5;
        end else if (op_q == 8'h76) begin
          state_d = S_HALT;
        end else begin
          state_d = S_T1;
        end
      end
      S_T5: begin
        {bc_rw, de_rw, hl_rw} = pair_sel(ddd);
        rreg_wr               = ddd[0];
        lreg_wr               = ~ddd[0];
        alu_a_to_dbus         = 1'b1;
        sel_alu_a             = 1'b1;
        state_d               = S_T1;
      end
      S_HALT: halt_ack = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m1_sequencer.sv
// Directed bench for m1_sequencer: fetch, wait states, MOV decode, HALT and asynchronous reset.
module tb_m1_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [7:0] data_in;
  logic [2:0] t_state;
  logic ale, rd_n, halt_ack, pc_rw, bc_rw, de_rw, hl_rw;
  logic dreg_rd, dreg_wr, dreg_inc, dreg_cnt;
  logic rreg_rd, lreg_rd, rreg_wr, lreg_wr;
  logic dbus_to_instr_reg, write_dbus_to_alu_tmp, alu_a_to_dbus, sel_alu_a;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  m1_sequencer dut (
    .clk(clk), .rst(rst), .ready(ready), .data_in(data_in), .t_state(t_state),
    .ale(ale), .rd_n(rd_n), .halt_ack(halt_ack), .pc_rw(pc_rw), .bc_rw(bc_rw),
    .de_rw(de_rw), .hl_rw(hl_rw), .dreg_rd(dreg_rd), .dreg_wr(dreg_wr),
    .dreg_inc(dreg_inc), .dreg_cnt(dreg_cnt), .rreg_rd(rreg_rd), .lreg_rd(lreg_rd),
    .rreg_wr(rreg_wr), .lreg_wr(lreg_wr), .dbus_to_instr_reg(dbus_to_instr_reg),
    .write_dbus_to_alu_tmp(write_dbus_to_alu_tmp), .alu_a_to_dbus(alu_a_to_dbus),
    .sel_alu_a(sel_alu_a)
  );

  logic [18:0] obs;
  assign obs = {ale, rd_n, halt_ack, pc_rw, bc_rw, de_rw, hl_rw, dreg_rd, dreg_wr,
                dreg_inc, dreg_cnt, rreg_rd, lreg_rd, rreg_wr, lreg_wr,
                dbus_to_instr_reg, write_dbus_to_alu_tmp, alu_a_to_dbus, sel_alu_a};

  localparam logic [18:0] ALE = 19'h1 << 18, RDN = 19'h1 << 17, HACK = 19'h1 << 16;
  localparam logic [18:0] PC  = 19'h1 << 15, BC  = 19'h1 << 14, DE   = 19'h1 << 13;
  localparam logic [18:0] HL  = 19'h1 << 12, DRD = 19'h1 << 11;
  localparam logic [18:0] DINC = 19'h1 << 9, DCNT = 19'h1 << 8, RRD = 19'h1 << 7;
  localparam logic [18:0] LRD = 19'h1 << 6, RWR = 19'h1 << 5, LWR = 19'h1 << 4;
  localparam logic [18:0] DIR = 19'h1 << 3, WTMP = 19'h1 << 2, AAD = 19'h1 << 1, SAA = 19'h1;

  localparam logic [18:0] V_IDLE = RDN;
  localparam logic [18:0] V_T1   = ALE | RDN | PC | DRD;
  localparam logic [18:0] V_T2   = PC | DINC | DCNT;
  localparam logic [18:0] V_TW   = 19'h0;
  localparam logic [18:0] V_T3   = DIR;
  localparam logic [18:0] V_T4N  = RDN;
  localparam logic [18:0] V_HALT = RDN | HACK;

  task automatic test_reset();
    logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    rst = 1'b0; ready = 1'b1; data_in = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (t_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state t_state=%0d exp=0", t_state);
    end
    n_checks++;
    if (obs !== V_IDLE) begin
      n_fail++; $display("FAIL reset_outputs obs=%h exp=%h", obs, V_IDLE);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i]) begin
        n_fail++; $display("FAIL reset_release[%0d] t_state=%0d exp=%0d", i, t_state, es[i]);
      end
    end
  endtask

  task automatic test_fetch_nop();
    logic [2:0]  es [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [18:0] ev [8] = '{V_T1, V_T2, V_T3, V_T4N, V_T1, V_T2, V_T3, V_T4N};
    data_in = 8'h00; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i] || obs !== ev[i]) begin
        n_fail++;
        $display("FAIL fetch_nop[%0d] t_state=%0d obs=%h exp t_state=%0d obs=%h",
                 i, t_state, obs, es[i], ev[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [2:0]  es [6] = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd3, 3'd4};
    logic [18:0] ev [6] = '{V_T1, V_T2, V_TW, V_TW, V_T3, V_T4N};
    int inc_cnt = 0;
    data_in = 8'h00; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dreg_inc) inc_cnt++;
      n_checks++;
      if (t_state !== es[i] || obs !== ev[i]) begin
        n_fail++;
        $display("FAIL wait_states[%0d] t_state=%0d obs=%h exp t_state=%0d obs=%h",
                 i, t_state, obs, es[i], ev[i]);
      end
      if (i == 0) ready = 1'b0;
      if (i == 3) ready = 1'b1;
    end
    n_checks++;
    if (inc_cnt !== 1) begin
      n_fail++; $display("FAIL wait_inc_count got=%0d exp=1", inc_cnt);
    end
  endtask

  task automatic test_mov();
    logic [2:0]  es [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [18:0] ev [9] = '{V_T1, V_T2, V_T3, RDN | DE | RRD | WTMP,
                            RDN | BC | LWR | AAD | SAA, V_T1, V_T2, V_T3, V_T4N};
    data_in = 8'h43; ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i] || obs !== ev[i]) begin
        n_fail++;
        $display("FAIL mov[%0d] t_state=%0d obs=%h exp t_state=%0d obs=%h",
                 i, t_state, obs, es[i], ev[i]);
      end
      if (i == 3) data_in = 8'h7E;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  es [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [18:0] ev [10] = '{V_T1, V_T2, V_T3, RDN | HL | LRD | WTMP,
                             RDN | HL | RWR | AAD | SAA, V_T1, V_T2, V_T3,
                             RDN | BC | LRD | WTMP, RDN | BC | LWR | AAD | SAA};
    data_in = 8'h6C; ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i] || obs !== ev[i]) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] t_state=%0d obs=%h exp t_state=%0d obs=%h",
                 i, t_state, obs, es[i], ev[i]);
      end
      if (i == 3) data_in = 8'h40;
    end
  endtask

  task automatic test_halt();
    logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    data_in = 8'h76; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i]) begin
        n_fail++; $display("FAIL halt_fetch[%0d] t_state=%0d exp=%0d", i, t_state, es[i]);
      end
    end
    data_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== 3'd7 || obs !== V_HALT) begin
        n_fail++;
        $display("FAIL halt_hold[%0d] t_state=%0d obs=%h exp t_state=7 obs=%h",
                 i, t_state, obs, V_HALT);
      end
      ready = ~ready;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (t_state !== 3'd0 || obs !== V_IDLE) begin
      n_fail++; $display("FAIL halt_reset t_state=%0d obs=%h exp t_state=0 obs=%h",
                         t_state, obs, V_IDLE);
    end
    @(negedge clk);
    rst = 1'b1; ready = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [2:0]  es [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    logic [18:0] ev [5] = '{V_T1, V_T2, V_T3, V_T4N, V_T1};
    data_in = 8'h00; ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (t_state !== 3'd6) begin
      n_fail++; $display("FAIL pre_tw_state t_state=%0d exp=6", t_state);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (t_state !== 3'd0 || obs !== V_IDLE) begin
      n_fail++; $display("FAIL async_rst_tw t_state=%0d obs=%h exp t_state=0 obs=%h",
                         t_state, obs, V_IDLE);
    end
    @(negedge clk);
    rst = 1'b1; ready = 1'b1; data_in = 8'h43;
    repeat (5) @(negedge clk);
    n_checks++;
    if (t_state !== 3'd5) begin
      n_fail++; $display("FAIL pre_t5_state t_state=%0d exp=5", t_state);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (t_state !== 3'd0 || obs !== V_IDLE) begin
      n_fail++; $display("FAIL async_rst_t5 t_state=%0d obs=%h exp t_state=0 obs=%h",
                         t_state, obs, V_IDLE);
    end
    @(negedge clk);
    rst = 1'b1; data_in = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (t_state !== es[i] || obs !== ev[i]) begin
        n_fail++;
        $display("FAIL restart[%0d] t_state=%0d obs=%h exp t_state=%0d obs=%h",
                 i, t_state, obs, es[i], ev[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_nop();
    test_wait_states();
    test_mov();
    test_back_to_back();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/m1_sequencer.md
# m1_sequencer

Timing-and-control sequencer that drives the 8085 datapath control lines for the opcode-fetch machine cycle and for register-to-register MOV, replacing hand-driven stimulus in the datapath bench. It steps T-states T1..T5 with optional wait states (TW) and a HALT state. It samples the fetched opcode and emits register-file, instruction-register and ALU-path strobes with fixed per-state timing. It sits between the instruction register/data bus and the `top` datapath control inputs.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- ready  in  1  memory ready; sampled at the end of T2 and TW
- data_in  in  8  data bus; opcode sampled at the end of T3
- t_state  out  3  0=IDLE, 1..5=T1..T5, 6=TW, 7=HALT
- ale  out  1  address latch enable
- rd_n  out  1  memory read strobe, active-low
- halt_ack  out  1  high in HALT
- pc_rw, bc_rw, de_rw, hl_rw  out  1 each  register-pair selects
- dreg_rd, dreg_wr, dreg_inc, dreg_cnt  out  1 each  pair read/write/increment controls
- rreg_rd, lreg_rd, rreg_wr, lreg_wr  out  1 each  low/high byte bus access
- dbus_to_instr_reg  out  1  load instruction register
- write_dbus_to_alu_tmp  out  1  load ALU temp from data bus
- alu_a_to_dbus, sel_alu_a  out  1 each  drive ALU temp onto data bus

## Operation
- State register and the 8-bit opcode register are the only storage. Outputs are combinational decodes of the state and the opcode register. Any output not listed for a state is 0. rd_n is 1 unless listed.
- IDLE: all outputs inactive. Next state is T1.
- T1: ale, pc_rw, dreg_rd.
- T2: pc_rw, dreg_inc, dreg_cnt, rd_n=0.
  - Next state is T3 if ready=1, otherwise TW.
- TW: rd_n=0.
  - Next state is T3 if ready=1, otherwise TW. There is no limit on the number of wait states.
- T3: rd_n=0, dbus_to_instr_reg.
  - The opcode register loads data_in on the exit edge. Next state is T4.
- T4: decode the opcode.
  - MOV: opcode = 01DDDSSS with DDD and SSS both in {000..101}. Codes: B=000, C=001, D=010, E=011, H=100, L=101.
    - Assert the source pair select: B/C→bc_rw, D/E→de_rw, H/L→hl_rw.
    - Even SSS asserts lreg_rd; odd SSS asserts rreg_rd.
    - Assert write_dbus_to_alu_tmp. Next state is T5.
  - Opcode 0x76 (HLT): no strobes; next state is HALT.
  - Any other opcode, including those that use A (111) or M (110) as an operand: no strobes; next state is T1.
- T5: assert the destination pair select (same mapping as T4, using DDD).
  - Even DDD asserts lreg_wr; odd DDD asserts rreg_wr.
  - Also assert alu_a_to_dbus and sel_alu_a. Next state is T1.
- HALT: halt_ack=1, all other outputs inactive. HALT is left only by reset.
- MOV with DDD=SSS (e.g. 0x40) runs the full T4/T5 sequence as normal.
- Reset (rst=0) at any time, including mid-TW or mid-T5:
  - The state goes to IDLE immediately (asynchronously) and the opcode register clears to 0x00.
  - All outputs go inactive within the same cycle.

## Timing
- Non-MOV fetch: 4 cycles (T1–T4).
- MOV: 5 cycles.
- Each TW adds 1 cycle.
- The first T1 begins at the first rising edge after rst deasserts.
- ready and data_in are sampled only on the rising edge that leaves T2/TW and T3 respectively; their values in other states are ignored.
- The PC increment strobe (dreg_inc with dreg_cnt) is asserted exactly one cycle per fetch, in T2, regardless of wait states.
- The opcode is stable from the T4 cycle until the next T3 exit edge, so the T5 decode uses the same opcode as T4.
- Outputs change only after a rising clock edge or on the asynchronous assertion of rst.

## Test plan
- Reset: hold rst=0 → t_state=0, rd_n=1, every other output 0. Release rst → t_state sequence 1,2,3,4.
- Fetch of 0x00 with ready=1 → t_state repeats 1,2,3,4. The following hold, with no other strobes asserted:
  - ale=1 only in T1.
  - pc_rw=1 in T1 and T2.
  - dreg_inc=1 only in T2.
  - dbus_to_instr_reg=1 only in T3.
- Wait states: ready=0 for 2 cycles starting in T2 → t_state 2,6,6,3. rd_n stays 0 through T2..T3, and dreg_inc is asserted for 1 cycle only.
- Fetch 0x43 (MOV B,E):
  - T4: de_rw=1, rreg_rd=1, write_dbus_to_alu_tmp=1.
  - T5: bc_rw=1, lreg_wr=1, alu_a_to_dbus=1, sel_alu_a=1.
  - Next state is T1. Then fetch 0x7E (MOV A,M) → 4-cycle fetch with no T5.
- Fetch 0x76 → after T4, t_state=7 and halt_ack=1 held for ≥10 cycles with ready toggling. Reset → IDLE.
- Assert rst=0 mid-TW and again mid-T5 → t_state=0 and all strobes 0 without waiting for a clock edge. Restart fetches 0x00 correctly.
